regfile_wb_ctrl: RTL and testbench

Writeback controller for the 32×32 register file. It shares the register file's single write port among `NREQ` writeback requesters (ALU, MEM, MUL, …) using round-robin arbitration, and registers the winning write onto `w_enable`/`w_addr`/`w_data`. It also keeps a per-register pending-write scoreboard so the issue stage can detect read-after-write hazards. It sits between the execution units and the `regfile` write port.

---
 rtl/regfile_wb_ctrl.sv | 132 +++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_ctrl
//  Purpose  : Round-robin writeback arbiter for the register file write port,
//             with a per-register pending-write scoreboard for RAW hazards.
//  Options  : REGFILE_R0_ZERO_EN - register 0 hardwired (never written/busy)
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl #(
    parameter int NREQ = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0][4:0]   req_addr,
    input  logic [NREQ-1:0][31:0]  req_data,
    output logic                   w_enable,
    output logic [4:0]             w_addr,
    output logic [31:0]            w_data,
    input  logic                   iss_valid,
    input  logic [4:0]             iss_rd,
    input  logic [4:0]             chk_r1,
    input  logic [4:0]             chk_r2,
    output logic                   hazard,
    output logic [31:0]            busy,
    output logic                   err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic            r_wen;
    logic [4:0]      r_waddr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_busy;
    logic            r_err;

    logic [NREQ-1:0] w_ready;
    logic            w_any;
    logic [PW-1:0]   w_grant;
    logic [PW-1:0]   w_ptr_nxt;
    logic [4:0]      w_sel_addr;
    logic [31:0]     w_sel_data;
    logic            w_wen_nxt;
    logic [31:0]     w_busy_nxt;
    logic            w_err_iss;
    logic            w_err_wr;

    // Scan ptr, ptr+1, ... modulo NREQ and take the first valid requester.
    always_comb begin
        int j;
        w_ready = '0;
        w_any   = 1'b0;
        w_grant = '0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_any && req_valid[PW'(j)]) begin
                w_any   = 1'b1;
                w_grant = PW'(j);
            end
        end
        if (w_any) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_ptr_nxt  = (w_grant == PW'(NREQ - 1)) ? '0 : w_grant + 1'b1;
    assign w_sel_addr = req_addr[w_grant];
    assign w_sel_data = req_data[w_grant];

`ifdef REGFILE_R0_ZERO_EN
    // Writes to r0 are consumed but never reach the register file.
    assign w_wen_nxt = w_any && (w_sel_addr != 5'd0);
`else
    assign w_wen_nxt = w_any;
`endif

    // Clear on commit first, then set, so a same-edge issue keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen) begin
            w_busy_nxt[r_waddr] = 1'b0;
        end
        if (iss_valid) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
`ifdef REGFILE_R0_ZERO_EN
        w_busy_nxt[0] = 1'b0;
`endif
    end

    // Reissuing a register whose write commits this very edge is legal.
    assign w_err_iss = iss_valid && r_busy[iss_rd] && !(r_wen && (r_waddr == iss_rd));
    assign w_err_wr  = r_wen && !r_busy[r_waddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_wen  <= w_wen_nxt;
            r_busy <= w_busy_nxt;
            if (w_any) begin
                r_ptr   <= w_ptr_nxt;
                r_waddr <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
            if (w_err_iss || w_err_wr) begin
                r_err <= 1'b1;
            end
        end
    end

    assign req_ready = w_ready;
    assign w_enable  = r_wen;
    assign w_addr    = r_waddr;
    assign w_data    = r_wdata;
    assign busy      = r_busy;
    assign err       = r_err;
    assign hazard    = r_busy[chk_r1] | r_busy[chk_r2] | r_busy[iss_rd];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_ctrl
//  Purpose  : Directed vector bench for regfile_wb_ctrl (NREQ = 3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_ctrl;

    localparam int NREQ = 3;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][4:0]  req_addr;
    logic [NREQ-1:0][31:0] req_data;
    logic                  w_enable;
    logic [4:0]            w_addr;
    logic [31:0]           w_data;
    logic                  iss_valid;
    logic [4:0]            iss_rd;
    logic [4:0]            chk_r1;
    logic [4:0]            chk_r2;
    logic                  hazard;
    logic [31:0]           busy;
    logic                  err;

    int n_total = 0;
    int n_pass  = 0;

    regfile_wb_ctrl #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .w_enable  (w_enable),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .chk_r1    (chk_r1),
        .chk_r2    (chk_r2),
        .hazard    (hazard),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic        iv;
        logic [4:0]  ird, c1, c2;
        logic [2:0]  rdy;
        logic        hz;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] bsy;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic [2:0] v, logic iv, logic [4:0] ird, logic [4:0] c1,
                                logic [4:0] c2, logic [2:0] rdy, logic hz, logic wen,
                                logic [4:0] wa, logic [31:0] wd, logic [31:0] bsy);
        vec_t r;
        r.valid = v;   r.iv = iv;   r.ird = ird;  r.c1 = c1;  r.c2 = c2;
        r.a0 = 5'd1;   r.a1 = 5'd2; r.a2 = 5'd3;
        r.d0 = 32'h100; r.d1 = 32'h200; r.d2 = 32'h300;
        r.rdy = rdy;   r.hz = hz;   r.wen = wen;  r.wa = wa;  r.wd = wd;  r.bsy = bsy;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        chk_r1    = '0;
        chk_r2    = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_wen",   {31'd0, w_enable}, 32'd0);
        check("rst_waddr", {27'd0, w_addr},   32'd0);
        check("rst_wdata", w_data,            32'd0);
        check("rst_busy",  busy,              32'd0);
        check("rst_err",   {31'd0, err},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Requesters 0,1,2 write r1,r2,r3 round-robin while each is issued just ahead.
        tbl[0]  = mk(3'b111, 1, 1, 0, 0, 3'b001, 0, 1, 1, 32'h100, 32'h2);
        tbl[1]  = mk(3'b111, 1, 2, 1, 0, 3'b010, 1, 1, 2, 32'h200, 32'h4);
        tbl[2]  = mk(3'b111, 1, 3, 0, 0, 3'b100, 0, 1, 3, 32'h300, 32'h8);
        tbl[3]  = mk(3'b111, 1, 1, 3, 0, 3'b001, 1, 1, 1, 32'h100, 32'h2);
        tbl[4]  = mk(3'b111, 1, 2, 0, 0, 3'b010, 0, 1, 2, 32'h200, 32'h4);
        tbl[5]  = mk(3'b111, 1, 3, 0, 0, 3'b100, 0, 1, 3, 32'h300, 32'h8);
        tbl[6]  = mk(3'b000, 0, 0, 3, 0, 3'b000, 1, 0, 3, 32'h300, 32'h0);
        tbl[7]  = mk(3'b000, 1, 5, 0, 0, 3'b000, 0, 0, 3, 32'h300, 32'h20);
        tbl[8]  = mk(3'b010, 0, 0, 5, 0, 3'b010, 1, 1, 5, 32'hDEADBEEF, 32'h20);
        tbl[8].a1 = 5'd5;  tbl[8].d1 = 32'hDEADBEEF;
        tbl[9]  = mk(3'b000, 0, 0, 0, 5, 3'b000, 1, 0, 5, 32'hDEADBEEF, 32'h0);
        tbl[10] = mk(3'b000, 1, 7, 5, 0, 3'b000, 0, 0, 5, 32'hDEADBEEF, 32'h80);
        tbl[11] = mk(3'b100, 0, 0, 0, 0, 3'b100, 0, 1, 7, 32'h77, 32'h80);
        tbl[11].a2 = 5'd7; tbl[11].d2 = 32'h77;
        tbl[12] = mk(3'b000, 1, 7, 0, 0, 3'b000, 1, 0, 7, 32'h77, 32'h80);
        tbl[13] = mk(3'b001, 0, 0, 7, 0, 3'b001, 1, 1, 7, 32'h7007, 32'h80);
        tbl[13].a0 = 5'd7; tbl[13].d0 = 32'h7007;
        tbl[14] = mk(3'b000, 0, 0, 7, 0, 3'b000, 1, 0, 7, 32'h7007, 32'h0);
        tbl[15] = mk(3'b000, 0, 0, 0, 7, 3'b000, 0, 0, 7, 32'h7007, 32'h0);

        rst_n = 1'b1;
        idle_inputs();
        req_addr = '0;
        req_data = '0;
        #2;
        do_reset();
        check("rst_ready", {29'd0, req_ready}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            req_valid   = tbl[i].valid;
            req_addr[0] = tbl[i].a0;  req_addr[1] = tbl[i].a1;  req_addr[2] = tbl[i].a2;
            req_data[0] = tbl[i].d0;  req_data[1] = tbl[i].d1;  req_data[2] = tbl[i].d2;
            iss_valid   = tbl[i].iv;
            iss_rd      = tbl[i].ird;
            chk_r1      = tbl[i].c1;
            chk_r2      = tbl[i].c2;
            #1;
            check($sformatf("v%0d_ready", i),  {29'd0, req_ready}, {29'd0, tbl[i].rdy});
            check($sformatf("v%0d_hazard", i), {31'd0, hazard},    {31'd0, tbl[i].hz});
            step();
            check($sformatf("v%0d_wen", i),   {31'd0, w_enable}, {31'd0, tbl[i].wen});
            check($sformatf("v%0d_waddr", i), {27'd0, w_addr},   {27'd0, tbl[i].wa});
            check($sformatf("v%0d_wdata", i), w_data,            tbl[i].wd);
            check($sformatf("v%0d_busy", i),  busy,              tbl[i].bsy);
            check($sformatf("v%0d_err", i),   {31'd0, err},      32'd0);
        end

        // Write to r12 that was never issued.
        idle_inputs();
        req_valid = 3'b001; req_addr[0] = 5'd12; req_data[0] = 32'hC;
        step();
        check("unissued_wen",   {31'd0, w_enable}, 32'd1);
        check("unissued_waddr", {27'd0, w_addr},   32'd12);
        check("unissued_err0",  {31'd0, err},      32'd0);
        req_valid = '0;
        step();
        check("unissued_err1",  {31'd0, err},      32'd1);
        step();
        check("err_sticky",     {31'd0, err},      32'd1);

        // Reset while a write sits in the output stage.
        req_valid = 3'b010; req_addr[1] = 5'd4; req_data[1] = 32'h44;
        step();
        check("midrst_wen_before", {31'd0, w_enable}, 32'd1);
        req_valid = '0;
        #2;
        do_reset();

        // Double issue of r9 without a write.
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        check("dbl_busy9", {31'd0, busy[9]}, 32'd1);
        check("dbl_err0",  {31'd0, err},     32'd0);
        step();
        check("dbl_err1",  {31'd0, err},     32'd1);
        iss_valid = 1'b0;
        step();
        check("dbl_err_hold", {31'd0, err}, 32'd1);
        #2;
        do_reset();

        // Requester 2 holds while requester 0 wins from ptr=0.
        req_valid   = 3'b101;
        req_addr[0] = 5'd20; req_data[0] = 32'h2020;
        req_addr[2] = 5'd21; req_data[2] = 32'hA5A5A5A5;
        #1;
        check("fair_ready0", {29'd0, req_ready}, 32'b001);
        step();
        check("fair_ready1", {29'd0, req_ready}, 32'b100);
        check("fair_waddr0", {27'd0, w_addr},    32'd20);
        step();
        req_valid = '0;
        check("fair_waddr1", {27'd0, w_addr},    32'd21);
        check("fair_wdata1", w_data,             32'hA5A5A5A5);
        #2;
        do_reset();

        // Request and issue targeting r0.
        req_valid = 3'b001; req_addr[0] = 5'd0; req_data[0] = 32'h55;
        iss_valid = 1'b1;   iss_rd = 5'd0;
        #1;
        check("r0_ready", {29'd0, req_ready}, 32'b001);
        step();
        idle_inputs();
`ifdef REGFILE_R0_ZERO_EN
        check("r0_wen",   {31'd0, w_enable}, 32'd0);
        check("r0_busy0", {31'd0, busy[0]},  32'd0);
`else
        check("r0_wen",   {31'd0, w_enable}, 32'd1);
        check("r0_waddr", {27'd0, w_addr},   32'd0);
        check("r0_busy0", {31'd0, busy[0]},  32'd1);
`endif
        step();
        check("r0_err",   {31'd0, err}, 32'd0);
        check("r0_busy",  busy,         32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
